// File: rtl/wb_cmd_pkg.sv
// wb_cmd_pkg: shared definitions for the Wishbone command master and the
// host-side front ends that feed it.
//   - state encoding of the command master FSM
//   - register bus widths (5-bit address, 8-bit data)
//   - default strobe timeout in cycles
package wb_cmd_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUS  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam int WB_ADR_W = 5;
    localparam int WB_DAT_W = 8;

    localparam int TIMEOUT_DEFAULT = 15;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        BUS  = ST_BUS,
        RESP = ST_RESP
    } state_t;

endpackage

// File: rtl/wb_cmd_timeout.sv
// wb_cmd_timeout: 8-bit strobe-age counter for the Wishbone command master.
// Ports:
//   clk      clock, rising edge
//   srst     synchronous active-high reset (count -> 0)
//   clr      synchronous clear (count -> 0)
//   en       increment this cycle
//   expired  count has reached TIMEOUT-1 (decoded from the registered count)
module wb_cmd_timeout #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic srst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    logic [7:0] count_reg;

    always_ff @(posedge clk) begin
        if (srst || clr) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= count_reg + 8'd1;
        end
    end

    // The first strobe cycle sees count 0, so expiry on LAST ends the
    // transfer after exactly TIMEOUT strobe cycles.
    assign expired = (count_reg == LAST);

endmodule

// File: rtl/wb_cmd_master.sv
// wb_cmd_master: Wishbone classic single-transfer initiator for the CPLD
// register bus. A valid/ready command becomes one read or write; the result
// (read data or timeout error) is returned on a valid/ready response.
// Optional feature macro: WB_CMD_MASTER_TIMEOUT_EN (strobe timeout abort).
// Ports:
//   wb_clk_i, wb_rst_i            clock, synchronous active-high reset
//   cmd_valid/cmd_ready           command handshake; cmd_we/cmd_adr/cmd_dat
//   rsp_valid/rsp_ready           response handshake; rsp_dat/rsp_err
//   busy                          not in IDLE
//   wb_cyc_o/stb_o/we_o/adr_o/dat_o  bus outputs (registered)
//   wb_dat_i, wb_ack_i            slave read data and acknowledge
module wb_cmd_master
    import wb_cmd_pkg::*;
#(
    parameter int ADR_WIDTH = WB_ADR_W,
    parameter int DAT_WIDTH = WB_DAT_W,
    parameter int TIMEOUT   = TIMEOUT_DEFAULT
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_we,
    input  logic [ADR_WIDTH-1:0] cmd_adr,
    input  logic [DAT_WIDTH-1:0] cmd_dat,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DAT_WIDTH-1:0] rsp_dat,
    output logic                 rsp_err,
    output logic                 busy,
    output logic                 wb_cyc_o,
    output logic                 wb_stb_o,
    output logic                 wb_we_o,
    output logic [ADR_WIDTH-1:0] wb_adr_o,
    output logic [DAT_WIDTH-1:0] wb_dat_o,
    input  logic [DAT_WIDTH-1:0] wb_dat_i,
    input  logic                 wb_ack_i
);

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
        $error("wb_cmd_master: TIMEOUT must be within 1..255");
    end

    state_t                 state_reg;
    logic                   stb_reg;
    logic                   we_reg;
    logic [ADR_WIDTH-1:0]   adr_reg;
    logic [DAT_WIDTH-1:0]   dat_reg;
    logic                   rsp_valid_reg;
    logic [DAT_WIDTH-1:0]   rsp_dat_reg;

`ifdef WB_CMD_MASTER_TIMEOUT_EN
    logic rsp_err_reg;
    logic expired;

    // Counter is held clear while idle and only advances on strobe cycles
    // that were not acknowledged.
    wb_cmd_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (wb_clk_i),
        .srst    (wb_rst_i),
        .clr     (state_reg == IDLE),
        .en      ((state_reg == BUS) && !wb_ack_i),
        .expired (expired)
    );
`endif

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_reg     <= IDLE;
            stb_reg       <= 1'b0;
            we_reg        <= 1'b0;
            adr_reg       <= '0;
            dat_reg       <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_dat_reg   <= '0;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
            rsp_err_reg   <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (cmd_valid) begin
                        we_reg    <= cmd_we;
                        adr_reg   <= cmd_adr;
                        dat_reg   <= cmd_dat;
                        stb_reg   <= 1'b1;
                        state_reg <= BUS;
                    end
                end
                BUS: begin
                    // Ack takes priority over a simultaneous timeout. The
                    // slave's stale ack after stb drops lands in RESP/IDLE
                    // where it is never looked at.
                    if (wb_ack_i) begin
                        rsp_dat_reg   <= we_reg ? '0 : wb_dat_i;
                        stb_reg       <= 1'b0;
                        rsp_valid_reg <= 1'b1;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
                        rsp_err_reg   <= 1'b0;
`endif
                        state_reg     <= RESP;
                    end
`ifdef WB_CMD_MASTER_TIMEOUT_EN
                    else if (expired) begin
                        rsp_dat_reg   <= '0;
                        rsp_err_reg   <= 1'b1;
                        stb_reg       <= 1'b0;
                        rsp_valid_reg <= 1'b1;
                        state_reg     <= RESP;
                    end
`endif
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = (state_reg == IDLE);
    assign busy      = (state_reg != IDLE);

    // Single-transfer master: cyc and stb always move together.
    assign wb_cyc_o  = stb_reg;
    assign wb_stb_o  = stb_reg;
    assign wb_we_o   = we_reg;
    assign wb_adr_o  = adr_reg;
    assign wb_dat_o  = dat_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_dat   = rsp_dat_reg;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
    assign rsp_err   = rsp_err_reg;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_wb_cmd_master.sv
// tb_wb_cmd_master: randomized and directed bench for wb_cmd_master with a
// registered-ack register-file slave and a transaction-level model.
module tb_wb_cmd_master;

    localparam int AW = 5;
    localparam int DW = 8;
    localparam int TO = 15;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_we;
    logic [AW-1:0] cmd_adr;
    logic [DW-1:0] cmd_dat;
    logic          rsp_valid, rsp_ready, rsp_err, busy;
    logic [DW-1:0] rsp_dat;
    logic          wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i;
    logic [AW-1:0] wb_adr_o;
    logic [DW-1:0] wb_dat_o, wb_dat_i;

    always #5 clk = ~clk;

    wb_cmd_master #(.ADR_WIDTH(AW), .DAT_WIDTH(DW), .TIMEOUT(TO)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_dat(cmd_dat),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
        .rsp_err(rsp_err), .busy(busy),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
        .wb_ack_i(wb_ack_i)
    );

    // ---------------- slave: register file, ack = registered stb ----------
    logic [DW-1:0] init_mem [32];
    logic [DW-1:0] mem      [32];
    logic          ack_en;

    always @(posedge clk) begin
        wb_ack_i <= ack_en && wb_stb_o;
        if (rst) mem <= init_mem;
        else if (wb_stb_o && wb_ack_i && wb_we_o) mem[wb_adr_o] <= wb_dat_o;
    end
    assign wb_dat_i = mem[wb_adr_o];

    // ---------------- response-ready driver ------------------------------
    logic rnd_mode, rdy_fixed;
    always @(posedge clk) begin
        #1;
        rsp_ready = rnd_mode ? 1'($urandom_range(0, 1)) : rdy_fixed;
    end

    // ---------------- checking -------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
    endtask

    // Transaction-level model: one transfer in flight; each accepted command
    // defines its strobe window, response start and expected result.
    int            cyc_n = 0;
    bit            m_busy = 0;
    int            s_start, s_end, r_start;
    logic          m_we;
    logic [AW-1:0] m_adr;
    logic [DW-1:0] m_dat, m_rdat;
    logic          m_err;
    logic [DW-1:0] model_mem [32];

    int            n_rsp = 0, n_acc = 0;
    int            last_acc = 0, last_stb_rise = 0, last_rv_rise = 0;
    int            stb_run = 0, last_stb_len = 0;
    logic [DW-1:0] last_rsp_dat;
    logic          last_rsp_err;
    logic          prev_stb = 0, prev_rv = 0;

    always @(negedge clk) begin
        cyc_n++;
        if (rst) begin
            m_busy    = 0;
            stb_run   = 0;
            prev_stb  = 0;
            prev_rv   = 0;
            model_mem = init_mem;
        end else begin
            chk("cmd_ready", {31'd0, cmd_ready}, {31'd0, !m_busy});
            chk("busy", {31'd0, busy}, {31'd0, m_busy});
            chk("stb", {31'd0, wb_stb_o},
                {31'd0, m_busy && cyc_n >= s_start && cyc_n <= s_end});
            chk("cyc", {31'd0, wb_cyc_o}, {31'd0, wb_stb_o});
            chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_busy && cyc_n >= r_start});
            if (wb_stb_o && m_busy) begin
                chk("wb_we", {31'd0, wb_we_o}, {31'd0, m_we});
                chk("wb_adr", 32'(wb_adr_o), 32'(m_adr));
                chk("wb_dat", 32'(wb_dat_o), 32'(m_dat));
            end
            if (rsp_valid && m_busy) begin
                chk("rsp_dat", 32'(rsp_dat), 32'(m_rdat));
                chk("rsp_err", {31'd0, rsp_err}, {31'd0, m_err});
            end
            if (wb_stb_o && !prev_stb) last_stb_rise = cyc_n;
            if (rsp_valid && !prev_rv) last_rv_rise = cyc_n;
            prev_stb = wb_stb_o;
            prev_rv  = rsp_valid;
            if (wb_stb_o) stb_run++;
            else if (stb_run > 0) begin
                last_stb_len = stb_run;
                stb_run = 0;
            end
            if (rsp_valid && rsp_ready) begin
                n_rsp++;
                last_rsp_dat = rsp_dat;
                last_rsp_err = rsp_err;
                m_busy = 0;
            end
            if (cmd_valid && cmd_ready) begin
                n_acc++;
                last_acc = cyc_n;
                m_busy   = 1;
                m_we     = cmd_we;
                m_adr    = cmd_adr;
                m_dat    = cmd_dat;
                s_start  = cyc_n + 1;
                if (ack_en) begin
                    s_end  = cyc_n + 2;
                    m_err  = 1'b0;
                    m_rdat = cmd_we ? '0 : model_mem[cmd_adr];
                    if (cmd_we) model_mem[cmd_adr] = cmd_dat;
                end else begin
                    s_end  = TO_EN ? cyc_n + TO : 32'h3fff_ffff;
                    m_err  = TO_EN;
                    m_rdat = '0;
                end
                r_start = s_end + 1;
            end
        end
    end

    // ---------------- stimulus tasks -------------------------------------
    task automatic send(input logic we, input logic [AW-1:0] adr,
                        input logic [DW-1:0] dat, input bit keep);
        bit ok = 0;
        if (!cmd_valid) begin
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        if (!keep) cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    int a1, a2, n0;

    initial begin
        for (int i = 0; i < 32; i++) init_mem[i] = 8'($urandom);
        init_mem[2] = 8'h5A;
        rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0;
        ack_en = 1'b1; rnd_mode = 1'b0; rdy_fixed = 1'b1; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_stb", {31'd0, wb_stb_o}, 32'd0);
        chk("rst_adr_dat", {19'd0, wb_adr_o, wb_dat_o}, 32'd0);
        chk("rst_rsp", {23'd0, rsp_valid, rsp_dat}, 32'd0);

        // Write adr 6 = 0x03; latency offsets
        send(1'b1, 5'd6, 8'h03, 0);
        wait_idle();
        chk("wr_stb_latency", 32'(last_stb_rise - last_acc), 32'd1);
        chk("wr_rsp_latency", 32'(last_rv_rise - last_stb_rise), 32'd2);
        chk("wr_rsp", {23'd0, last_rsp_err, last_rsp_dat}, 32'd0);

        // Read adr 2 = 0x5A; stale ack yields no extra response
        send(1'b0, 5'd2, 8'h00, 0);
        wait_idle();
        chk("rd_dat", 32'(last_rsp_dat), 32'h5A);
        n0 = n_rsp;
        repeat (4) @(negedge clk);
        chk("no_stale_rsp", 32'(n_rsp), 32'(n0));

        // Read back the write
        send(1'b0, 5'd6, 8'h00, 0);
        wait_idle();
        chk("rd_back", 32'(last_rsp_dat), 32'h03);

        // Back-to-back with cmd_valid held
        n0 = n_rsp;
        send(1'b0, 5'd0, 8'h00, 1);
        a1 = last_acc;
        send(1'b0, 5'd1, 8'h00, 0);
        a2 = last_acc;
        wait_idle();
        chk("b2b_spacing", 32'(a2 - a1), 32'd4);
        chk("b2b_rsp_count", 32'(n_rsp - n0), 32'd2);

        // Response back-pressure
        rdy_fixed = 1'b0;
        send(1'b0, 5'd2, 8'h00, 0);
        repeat (8) @(negedge clk);
        chk("bp_hold", {29'd0, rsp_valid, busy, cmd_ready}, 32'b110);
        rdy_fixed = 1'b1;
        wait_idle();
        chk("bp_dat", 32'(last_rsp_dat), 32'h5A);

        // No ack
        ack_en = 1'b0;
        n0 = n_rsp;
        send(1'b0, 5'd3, 8'h00, 0);
        if (TO_EN) begin
            wait_idle();
            chk("to_stb_len", 32'(last_stb_len), 32'(TO));
            chk("to_rsp", {23'd0, last_rsp_err, last_rsp_dat}, 32'h100);
        end else begin
            repeat (100) @(negedge clk);
            chk("noack_stb_held", {31'd0, wb_stb_o}, 32'd1);
            chk("noack_no_rsp", 32'(n_rsp), 32'(n0));
            @(posedge clk);
            #1 rst = 1'b1;
            @(posedge clk);
            #1 rst = 1'b0;
        end
        ack_en = 1'b1;

        // Reset pulse in BUS
        n0 = n_rsp;
        send(1'b0, 5'd4, 8'h00, 0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rstbus_released", {29'd0, wb_cyc_o, wb_stb_o, rsp_valid}, 32'd0);
        chk("rstbus_idle", {30'd0, cmd_ready, busy}, 32'b10);
        repeat (5) @(negedge clk);
        chk("rstbus_no_rsp", 32'(n_rsp), 32'(n0));

        // Randomized traffic
        rnd_mode = 1'b1;
        n0 = n_rsp;
        for (int t = 0; t < 60; t++) begin
            ack_en = TO_EN ? ($urandom_range(0, 7) != 0) : 1'b1;
            send(1'($urandom_range(0, 1)), 5'($urandom), 8'($urandom), 0);
            wait_idle();
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        chk("rnd_rsp_count", 32'(n_rsp - n0), 32'd60);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
